next_pc_seq: RTL and testbench
==============================

# next_pc_seq

Parametrised program-counter sequencer for the MIPS core. It holds the PC register and selects the next fetch address each cycle: sequential increment, absolute branch, call with a return-address stack, return, or a context-base load. Branch and call targets are relocated by a programmable context base. It sits between the control unit and instruction memory, replacing the combinational next-address selector and adding real jump-context support.

## Interface
- ADDR_W, 11: PC/address width in bits (valid range 4..32).
- STACK_DEPTH, 8: return-address stack entries (power of two, ≥2).
- RESET_PC, 0: PC value loaded at reset.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- stall  in  1  1 = hold every register; next_pc still computed.
- op  in  3  operation: 0 SEQ, 1 BRANCH, 2 CALL, 3 RET, 4 SETCTX; 5–7 treated as SEQ.
- imm  in  32  immediate; only imm[ADDR_W-1:0] is used.
- err_clr  in  1  clears sticky error flags.
- pc  out  ADDR_W  current fetch address (registered).
- next_pc  out  ADDR_W  address pc takes at the next unstalled edge (combinational).
- ctx_base  out  ADDR_W  current context base (registered).
- stack_count  out  $clog2(STACK_DEPTH)+1  valid stack entries.
- stack_ovf  out  1  sticky: CALL issued while stack full.
- stack_unf  out  1  sticky: RET issued while stack empty.

## Operation
- All address arithmetic is modulo 2^ADDR_W; carries are discarded.
- seq = pc + 1; tgt = imm[ADDR_W-1:0] + ctx_base.
- SEQ: next_pc = seq.
- BRANCH: next_pc = tgt.
- CALL: push seq; next_pc = tgt. When stack full: no push, count unchanged, stack_ovf set, jump still taken.
- RET: next_pc = top entry; pop. When stack empty: next_pc = seq, stack_unf set.
- SETCTX: ctx_base ← imm[ADDR_W-1:0]; next_pc = seq. The new base applies to targets from the following cycle onward.
- stall = 1: pc, ctx_base, stack contents, stack_count and flags all hold; the op is discarded rather than deferred.
- err_clr = 1 clears both flags. When an error occurs in the same cycle as err_clr, the set takes priority.
- Unused stack entries hold stale data and are not observable.

## Timing
- Reset (reset = 0 at an edge): pc = RESET_PC, ctx_base = 0, stack_count = 0, stack_ovf = stack_unf = 0. Reset overrides stall and any op.
- Reset mid-sequence discards stack contents, with no pop side effects.
- Latency: the op presented in cycle n takes effect at edge n+1. pc reflects it in cycle n+1.
- next_pc is valid in the same cycle as op/imm, with no registers in the path.
- Back-to-back CALL/RET are allowed every cycle. A RET directly after a CALL returns the address just pushed.
- Wrap-around: pc = 2^ADDR_W−1 with SEQ gives pc = 0. A target overflow wraps the same way.

## Structure
- Shared package `pc_seq_pkg`: op encodings (OP_SEQ, OP_BRANCH, OP_CALL, OP_RET, OP_SETCTX) and the op width constant.
- Sub-module `ras_lifo`: parametrised LIFO (ADDR_W, STACK_DEPTH) with push/pop/top/count/full/empty. Push-on-full and pop-on-empty are ignored internally.
- The top level holds the pc/ctx_base registers, the next-pc mux and the error flags.

## Test plan
- Reset then 3×SEQ with RESET_PC = 0 → pc 0,1,2,3; ctx_base 0; flags 0.
- SETCTX imm=0x100, then BRANCH imm=0x020 → pc = 0x120 two edges after SETCTX. With ADDR_W=11, SETCTX 0x7F0 + BRANCH 0x020 → pc = 0x010 (wrap).
- CALL from pc=5 to imm=0x40 (base 0), SEQ, RET → pc 0x40, 0x41, 6; stack_count 1 then 0.
- STACK_DEPTH=8: 9 nested CALLs → stack_count 8, stack_ovf = 1, 9th jump taken. 9 RETs → 8 correct returns, then pc+1 and stack_unf = 1. err_clr clears both.
- stall held 3 cycles during CALL → pc, stack_count unchanged, next_pc shows the target. Reset asserted while stall=1 and count=4 → pc = RESET_PC, count 0.
- pc = 0x7FF, SEQ (ADDR_W=11) → pc = 0x000. Ops 5–7 → behave as SEQ.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared op encodings and decode helper for the program-counter sequencer.
// Latency: none (types only); backpressure: n/a.
package pc_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_CALL   = 3'd2,
    OP_RET    = 3'd3,
    OP_SETCTX = 3'd4
  } opT;

  // Reserved encodings 5..7 fold onto SEQ so the mux only sees legal ops.
  function automatic opT decodeOp(input logic [OP_W-1:0] raw);
    case (raw)
      3'd1:    return OP_BRANCH;
      3'd2:    return OP_CALL;
      3'd3:    return OP_RET;
      3'd4:    return OP_SETCTX;
      default: return OP_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: push/pop update on the clock edge, top/count/full/empty are live.
// Latency: 1 edge for push/pop; backpressure: push-on-full and pop-on-empty are dropped.
module ras_lifo #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            pushData,
  output logic [ADDR_W-1:0]            topData,
  output logic [$clog2(STACK_DEPTH):0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]  wrIdx;
  logic [PTR_W-1:0]  topIdx;
  logic              doPush;
  logic              doPop;
  logic              doReplace;

  assign full    = (count == CNT_W'(STACK_DEPTH));
  assign empty   = (count == '0);
  assign wrIdx   = count[PTR_W-1:0];
  assign topIdx  = wrIdx - PTR_W'(1);
  assign topData = mem[topIdx];

  // Simultaneous push and pop on a non-empty stack replaces the top entry.
  assign doReplace = push && pop && !empty;
  assign doPush    = push && !full && !doReplace;
  assign doPop     = pop && !push && !empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (doPush) begin
      count <= count + CNT_W'(1);
    end else if (doPop) begin
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; slots above count are stale by design.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrIdx] <= pushData;
    end else if (doReplace) begin
      mem[topIdx] <= pushData;
    end
  end

endmodule

// File: rtl/next_pc_seq.sv
// PC register and next-fetch-address selector with context-relocated targets and a return stack.
// Latency: op in cycle n lands in pc at edge n+1, next_pc is combinational; backpressure: stall freezes all state and drops the op.
module next_pc_seq
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W      = 11,
  parameter int              STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [OP_W-1:0]              op,
  input  logic [31:0]                  imm,
  input  logic                         err_clr,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            next_pc,
  output logic [ADDR_W-1:0]            ctx_base,
  output logic [$clog2(STACK_DEPTH):0] stack_count,
  output logic                         stack_ovf,
  output logic                         stack_unf
);

  opT              curOp;
  logic [ADDR_W-1:0] seqPc;
  logic [ADDR_W-1:0] tgtPc;
  logic [ADDR_W-1:0] stkTop;
  logic              stkFull;
  logic              stkEmpty;
  logic              isCall;
  logic              isRet;
  logic              isCtx;
  logic              unusedImm;

  assign curOp     = decodeOp(op);
  assign seqPc     = pc + ADDR_W'(1);
  assign tgtPc     = imm[ADDR_W-1:0] + ctx_base;
  assign unusedImm = ^imm;

  always_comb begin
    isCall  = 1'b0;
    isRet   = 1'b0;
    isCtx   = 1'b0;
    next_pc = seqPc;
    case (curOp)
      OP_BRANCH: next_pc = tgtPc;
      OP_CALL: begin
        isCall  = 1'b1;
        next_pc = tgtPc;
      end
      OP_RET: begin
        isRet = 1'b1;
        if (!stkEmpty) next_pc = stkTop;
      end
      OP_SETCTX: isCtx = 1'b1;
      default: ;
    endcase
  end

  ras_lifo #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clock    (clock),
    .reset    (reset),
    .push     (isCall && !stall),
    .pop      (isRet && !stall),
    .pushData (seqPc),
    .topData  (stkTop),
    .count    (stack_count),
    .full     (stkFull),
    .empty    (stkEmpty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc       <= RESET_PC;
      ctx_base <= '0;
    end else if (!stall) begin
      pc <= next_pc;
      if (isCtx) ctx_base <= imm[ADDR_W-1:0];
    end
  end

  // A fresh error outranks a same-cycle clear so the event is never lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (!stall) begin
      if (isCall && stkFull) stack_ovf <= 1'b1;
      else if (err_clr)      stack_ovf <= 1'b0;
      if (isRet && stkEmpty) stack_unf <= 1'b1;
      else if (err_clr)      stack_unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_next_pc_seq.sv
// Scoreboard bench for next_pc_seq: a reference model queues expected state per op,
// checked one edge later; a few test-plan points are also checked against constants.
module tb_next_pc_seq;

  localparam int AW = 11;
  localparam int SD = 8;
  localparam int CW = $clog2(SD) + 1;
  localparam logic [AW-1:0] RPC = '0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          err_clr = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [31:0]   imm = '0;
  logic [AW-1:0] pc;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] ctx_base;
  logic [CW-1:0] stack_count;
  logic          stack_ovf;
  logic          stack_unf;

  always #5 clock = ~clock;

  next_pc_seq #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_PC(RPC)) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .op          (op),
    .imm         (imm),
    .err_clr     (err_clr),
    .pc          (pc),
    .next_pc     (next_pc),
    .ctx_base    (ctx_base),
    .stack_count (stack_count),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] ctx;
    int            cnt;
    logic          ovf;
    logic          unf;
  } expT;

  expT sbq[$];

  logic [AW-1:0] mPc = RPC;
  logic [AW-1:0] mCtx = '0;
  logic [AW-1:0] mStk [SD];
  int            mCnt = 0;
  logic          mOvf = 1'b0;
  logic          mUnf = 1'b0;

  int nVectors = 0;
  int nMiscompares = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rstN, input logic stl, input logic clr,
                      input logic [2:0] o, input logic [31:0] im);
    logic [AW-1:0] seqA;
    logic [AW-1:0] tgtA;
    logic [AW-1:0] nxt;
    expT e;
    @(negedge clock);
    reset   = rstN;
    stall   = stl;
    err_clr = clr;
    op      = o;
    imm     = im;
    seqA = mPc + 1'b1;
    tgtA = im[AW-1:0] + mCtx;
    case (o)
      3'd1, 3'd2: nxt = tgtA;
      3'd3:       nxt = (mCnt == 0) ? seqA : mStk[mCnt-1];
      default:    nxt = seqA;
    endcase
    #1;
    if (rstN) checkVal("next_pc", {21'd0, next_pc}, {21'd0, nxt});
    if (!rstN) begin
      mPc = RPC; mCtx = '0; mCnt = 0; mOvf = 1'b0; mUnf = 1'b0;
    end else if (!stl) begin
      if (clr) begin mOvf = 1'b0; mUnf = 1'b0; end
      case (o)
        3'd2: if (mCnt == SD) mOvf = 1'b1; else begin mStk[mCnt] = seqA; mCnt++; end
        3'd3: if (mCnt == 0) mUnf = 1'b1; else mCnt--;
        3'd4: mCtx = im[AW-1:0];
        default: ;
      endcase
      mPc = nxt;
    end
    e.pc = mPc; e.ctx = mCtx; e.cnt = mCnt; e.ovf = mOvf; e.unf = mUnf;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    if (sbq.size() == 0) begin
      checkVal("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      checkVal("pc", {21'd0, pc}, {21'd0, e.pc});
      checkVal("ctx_base", {21'd0, ctx_base}, {21'd0, e.ctx});
      checkVal("stack_count", {28'd0, stack_count}, e.cnt);
      checkVal("stack_ovf", {31'd0, stack_ovf}, {31'd0, e.ovf});
      checkVal("stack_unf", {31'd0, stack_unf}, {31'd0, e.unf});
    end
  endtask

  initial begin
    // reset, including with stall and an op pending
    step(1'b0, 1'b0, 1'b0, 3'd0, 0);
    step(1'b0, 1'b1, 1'b0, 3'd2, 32'h55);
    checkVal("reset_pc", {21'd0, pc}, 32'h0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 3'd0, 0);
    checkVal("seq3_pc", {21'd0, pc}, 32'h3);

    step(1'b1, 1'b0, 1'b0, 3'd4, 32'h100);
    step(1'b1, 1'b0, 1'b0, 3'd1, 32'h020);
    checkVal("ctx_branch", {21'd0, pc}, 32'h120);
    step(1'b1, 1'b0, 1'b0, 3'd4, 32'h7F0);
    step(1'b1, 1'b0, 1'b0, 3'd1, 32'h020);
    checkVal("tgt_wrap", {21'd0, pc}, 32'h010);

    // call / seq / ret from pc 5
    step(1'b1, 1'b0, 1'b0, 3'd4, 32'h0);
    step(1'b1, 1'b0, 1'b0, 3'd1, 32'h5);
    step(1'b1, 1'b0, 1'b0, 3'd2, 32'h40);
    step(1'b1, 1'b0, 1'b0, 3'd0, 0);
    step(1'b1, 1'b0, 1'b0, 3'd3, 0);
    checkVal("ret_pc", {21'd0, pc}, 32'h6);

    // nine nested calls overflow, nine rets underflow, then clear
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 3'd2, 32'h80 + i * 32'h10);
    checkVal("ovf_cnt", {28'd0, stack_count}, 32'd8);
    checkVal("ovf_flag", {31'd0, stack_ovf}, 32'd1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 3'd3, 0);
    checkVal("unf_flag", {31'd0, stack_unf}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 3'd0, 0);
    checkVal("clr_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);

    // underflow coincident with clear keeps the flag set
    step(1'b1, 1'b0, 1'b1, 3'd3, 0);
    // back-to-back call/ret pairs
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 3'd2, 32'h300 + i);
      step(1'b1, 1'b0, 1'b0, 3'd3, 0);
    end

    // stall during call, then reset under stall with four entries
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 3'd2, 32'h200 + i * 4);
    repeat (3) step(1'b1, 1'b1, 1'b0, 3'd2, 32'h600);
    checkVal("stall_cnt", {28'd0, stack_count}, 32'd4);
    step(1'b0, 1'b1, 1'b0, 3'd3, 0);
    checkVal("rst_stall_cnt", {28'd0, stack_count}, 32'd0);

    // pc wrap and reserved ops
    step(1'b1, 1'b0, 1'b0, 3'd1, 32'h7FF);
    step(1'b1, 1'b0, 1'b0, 3'd0, 0);
    checkVal("pc_wrap", {21'd0, pc}, 32'h0);
    for (int i = 5; i < 8; i++) step(1'b1, 1'b0, 1'b0, 3'(i), 32'h123);

    // random traffic
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
